// File: rtl/coin_acceptor.sv
// Coin front end: synchronizes and debounces three coin sensors, queues coin codes and
// issues spaced single-cycle pulses to the vending FSM. COIN_CREDIT_CNT_EN adds credit_total.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic coin_q_raw,
    input  logic busy,
    output logic nickel,
    output logic dime,
    output logic quarter,
    output logic reject,
`ifdef COIN_CREDIT_CNT_EN
    output logic [15:0] credit_total,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PEND_W = $clog2(FIFO_DEPTH+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [2:0] raw_lines;
    logic [2:0] rise;

    // Line index 0/1/2 carries coin code 1/2/3 (nickel/dime/quarter).
    assign raw_lines = {coin_q_raw, coin_d_raw, coin_n_raw};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_line
            logic             sync1_q, sync2_q;
            logic             level_q, level_d;
            logic             level_prev_q;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= raw_lines[gi];
                    sync2_q      <= sync1_q;
                    level_q      <= level_d;
                    level_prev_q <= level_q;
                    cnt_q        <= cnt_d;
                end
            end

            assign rise[gi] = level_q & ~level_prev_q;
        end
    endgenerate

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PEND_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             nickel_q, nickel_d;
    logic             dime_q, dime_d;
    logic             quarter_q, quarter_d;
    logic             reject_q, reject_d;

    logic       one_event;
    logic       multi_event;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic [1:0] push_code;
    logic [1:0] head_code;

    assign one_event   = (rise != 3'b000) && ((rise & (rise - 3'd1)) == 3'b000);
    assign multi_event = (rise != 3'b000) && !one_event;
    assign fifo_full   = (count_q == PEND_W'(FIFO_DEPTH));
    assign push        = one_event && !fifo_full;
    assign push_code   = rise[2] ? 2'd3 : (rise[1] ? 2'd2 : 2'd1);
    assign head_code   = mem_q[rd_ptr_q];
    assign pop         = (state_q == IDLE) && (count_q != '0) && !busy;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        nickel_d  = 1'b0;
        dime_d    = 1'b0;
        quarter_d = 1'b0;
        reject_d  = multi_event || (one_event && fifo_full);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + PEND_W'(push) - PEND_W'(pop);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = ISSUE;
                    nickel_d  = (head_code == 2'd1);
                    dime_d    = (head_code == 2'd2);
                    quarter_d = (head_code == 2'd3);
                end
            end
            ISSUE:   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            nickel_q  <= 1'b0;
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            nickel_q  <= nickel_d;
            dime_q    <= dime_d;
            quarter_q <= quarter_d;
            reject_q  <= reject_d;
        end
    end

    // Storage is left out of reset; the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign nickel  = nickel_q;
    assign dime    = dime_q;
    assign quarter = quarter_q;
    assign reject  = reject_q;
    assign pending = count_q;

`ifdef COIN_CREDIT_CNT_EN
    logic [15:0] credit_q, credit_d;
    logic [16:0] credit_sum;
    logic [4:0]  coin_value;

    always_comb begin
        coin_value = 5'd0;
        if (nickel_q) begin
            coin_value = 5'd5;
        end else if (dime_q) begin
            coin_value = 5'd10;
        end else if (quarter_q) begin
            coin_value = 5'd25;
        end
        credit_sum = {1'b0, credit_q} + 17'(coin_value);
        credit_d   = credit_sum[16] ? 16'hFFFF : credit_sum[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_total = credit_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (default parameters); credit checks run when
// COIN_CREDIT_CNT_EN is defined.
module tb_coin_acceptor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_n_raw = 1'b0;
    logic       coin_d_raw = 1'b0;
    logic       coin_q_raw = 1'b0;
    logic       busy = 1'b0;
    logic       nickel, dime, quarter, reject;
    logic [2:0] pending;
`ifdef COIN_CREDIT_CNT_EN
    logic [15:0] credit_total;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n_cnt, d_cnt, q_cnt, rej_cnt, tick_n, max_pend;
    int q_ticks[$];

    coin_acceptor dut (
        .clock        (clock),
        .reset        (reset),
        .coin_n_raw   (coin_n_raw),
        .coin_d_raw   (coin_d_raw),
        .coin_q_raw   (coin_q_raw),
        .busy         (busy),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .reject       (reject),
`ifdef COIN_CREDIT_CNT_EN
        .credit_total (credit_total),
`endif
        .pending      (pending)
    );

    always #5 clock = ~clock;

    task automatic clear_counts();
        n_cnt = 0; d_cnt = 0; q_cnt = 0; rej_cnt = 0; tick_n = 0; max_pend = 0;
        q_ticks.delete();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        tick_n++;
        if (nickel) n_cnt++;
        if (dime) d_cnt++;
        if (quarter) begin
            q_cnt++;
            q_ticks.push_back(tick_n);
        end
        if (reject) rej_cnt++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
    endtask

    task automatic coin(input int which, input int hi, input int lo);
        if (which == 0) coin_n_raw = 1'b1;
        if (which == 1) coin_d_raw = 1'b1;
        if (which == 2) coin_q_raw = 1'b1;
        repeat (hi) tick();
        coin_n_raw = 1'b0;
        coin_d_raw = 1'b0;
        coin_q_raw = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        if ({nickel, dime, quarter, reject} !== 4'b0000) begin
            $display("FAIL reset_outputs got %b want 0000", {nickel, dime, quarter, reject});
            miscompares++;
        end
        vectors++;
        if (pending !== 3'd0) begin
            $display("FAIL reset_pending got %0d want 0", pending);
            miscompares++;
        end
        vectors++;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        $display("test_reset done");
    endtask

    task automatic test_single_nickel();
        int first_n;
        int pend7;
        first_n = 0;
        pend7 = -1;
        clear_counts();
        coin_n_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) coin_n_raw = 1'b0;
            tick();
            if (i == 7) pend7 = int'(pending);
            if (nickel && first_n == 0) first_n = i;
        end
        if (n_cnt != 1) begin
            $display("FAIL nickel_count got %0d want 1", n_cnt);
            miscompares++;
        end
        vectors++;
        if (first_n != 8) begin
            $display("FAIL nickel_latency got edge %0d want edge 8", first_n);
            miscompares++;
        end
        vectors++;
        if (pend7 != 1) begin
            $display("FAIL nickel_pending_after_push got %0d want 1", pend7);
            miscompares++;
        end
        vectors++;
        if (d_cnt + q_cnt + rej_cnt != 0 || pending !== 3'd0) begin
            $display("FAIL nickel_side_effects got d=%0d q=%0d rej=%0d pend=%0d want 0 0 0 0",
                     d_cnt, q_cnt, rej_cnt, pending);
            miscompares++;
        end
        vectors++;
        $display("test_single_nickel: pulses=%0d at edge %0d", n_cnt, first_n);
    endtask

    task automatic test_bounce();
        clear_counts();
        for (int i = 1; i <= 30; i++) begin
            coin_d_raw = (i <= 4) ? (i % 2 == 1) : (i <= 14);
            tick();
        end
        coin_d_raw = 1'b0;
        if (d_cnt != 1 || n_cnt + q_cnt + rej_cnt != 0) begin
            $display("FAIL bounce_dime got d=%0d other=%0d want d=1 other=0",
                     d_cnt, n_cnt + q_cnt + rej_cnt);
            miscompares++;
        end
        vectors++;
        $display("test_bounce: dime pulses=%0d", d_cnt);

        clear_counts();
        for (int i = 1; i <= 20; i++) begin
            coin_d_raw = (i <= 3);
            tick();
        end
        if (d_cnt + n_cnt + q_cnt + rej_cnt != 0 || max_pend != 0) begin
            $display("FAIL glitch_no_event got pulses=%0d maxpend=%0d want 0 0",
                     d_cnt + n_cnt + q_cnt + rej_cnt, max_pend);
            miscompares++;
        end
        vectors++;
        $display("test_glitch: pulses=%0d", d_cnt);
    endtask

    task automatic test_backlog();
        int got;
        busy = 1'b1;
        clear_counts();
        repeat (5) coin(2, 8, 8);
        if (rej_cnt != 1 || q_cnt != 0) begin
            $display("FAIL backlog_reject got rej=%0d q=%0d want rej=1 q=0", rej_cnt, q_cnt);
            miscompares++;
        end
        vectors++;
        if (pending !== 3'd4) begin
            $display("FAIL backlog_pending got %0d want 4", pending);
            miscompares++;
        end
        vectors++;
        clear_counts();
        busy = 1'b0;
        repeat (15) tick();
        if (q_ticks.size() != 4) begin
            $display("FAIL backlog_drain_count got %0d want 4", q_ticks.size());
            miscompares++;
        end
        vectors++;
        for (int j = 0; j < 4; j++) begin
            got = (j < q_ticks.size()) ? q_ticks[j] : -1;
            if (got != 1 + 3 * j) begin
                $display("FAIL backlog_spacing[%0d] got edge %0d want edge %0d", j, got, 1 + 3 * j);
                miscompares++;
            end
            vectors++;
        end
        if (pending !== 3'd0) begin
            $display("FAIL backlog_empty got %0d want 0", pending);
            miscompares++;
        end
        vectors++;
        $display("test_backlog: drained %0d quarters", q_ticks.size());
    endtask

    task automatic test_simultaneous();
        int first_rej;
        first_rej = 0;
        clear_counts();
        coin_n_raw = 1'b1;
        coin_q_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) begin
                coin_n_raw = 1'b0;
                coin_q_raw = 1'b0;
            end
            tick();
            if (reject && first_rej == 0) first_rej = i;
        end
        if (rej_cnt != 1 || first_rej != 7) begin
            $display("FAIL simul_reject got count=%0d edge=%0d want count=1 edge=7", rej_cnt, first_rej);
            miscompares++;
        end
        vectors++;
        if (n_cnt + d_cnt + q_cnt != 0 || max_pend != 0) begin
            $display("FAIL simul_no_pulse got pulses=%0d maxpend=%0d want 0 0",
                     n_cnt + d_cnt + q_cnt, max_pend);
            miscompares++;
        end
        vectors++;
        $display("test_simultaneous: rejects=%0d", rej_cnt);
    endtask

    task automatic test_reset_mid_queue();
        busy = 1'b1;
        clear_counts();
        coin(0, 8, 8);
        coin(1, 8, 8);
        coin(2, 8, 8);
        if (pending !== 3'd3) begin
            $display("FAIL midq_pending got %0d want 3", pending);
            miscompares++;
        end
        vectors++;
        #3 reset = 1'b1;
        #1;
        if ({nickel, dime, quarter, reject} !== 4'b0000 || pending !== 3'd0) begin
            $display("FAIL midq_async_reset got out=%b pend=%0d want 0000 0",
                     {nickel, dime, quarter, reject}, pending);
            miscompares++;
        end
        vectors++;
        repeat (2) tick();
        reset = 1'b0;
        busy = 1'b0;
        clear_counts();
        repeat (20) tick();
        if (n_cnt + d_cnt + q_cnt + rej_cnt != 0 || max_pend != 0) begin
            $display("FAIL midq_after_release got pulses=%0d maxpend=%0d want 0 0",
                     n_cnt + d_cnt + q_cnt + rej_cnt, max_pend);
            miscompares++;
        end
        vectors++;
        coin(0, 8, 12);
        if (n_cnt != 1 || d_cnt + q_cnt + rej_cnt != 0) begin
            $display("FAIL midq_new_coin got n=%0d other=%0d want n=1 other=0",
                     n_cnt, d_cnt + q_cnt + rej_cnt);
            miscompares++;
        end
        vectors++;
        $display("test_reset_mid_queue: new coin pulses=%0d", n_cnt);
    endtask

`ifdef COIN_CREDIT_CNT_EN
    task automatic test_credit();
        busy = 1'b0;
        #3 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        coin(0, 8, 8);
        coin(1, 8, 8);
        coin(2, 8, 8);
        if (credit_total !== 16'd40) begin
            $display("FAIL credit_ndq got %0d want 40", credit_total);
            miscompares++;
        end
        vectors++;
        repeat (2619) coin(2, 6, 6);
        repeat (10) tick();
        if (credit_total !== 16'd65515) begin
            $display("FAIL credit_near_max got %0d want 65515", credit_total);
            miscompares++;
        end
        vectors++;
        coin(2, 6, 10);
        if (credit_total !== 16'd65535) begin
            $display("FAIL credit_saturate got %0d want 65535", credit_total);
            miscompares++;
        end
        vectors++;
        coin(0, 6, 10);
        if (credit_total !== 16'd65535) begin
            $display("FAIL credit_hold got %0d want 65535", credit_total);
            miscompares++;
        end
        vectors++;
        $display("test_credit: credit_total=%0d", credit_total);
    endtask
`endif

    initial begin
        test_reset();
        test_single_nickel();
        test_bounce();
        test_backlog();
        test_simultaneous();
        test_reset_mid_queue();
`ifdef COIN_CREDIT_CNT_EN
        test_credit();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
